// File: rtl/hazard_pkg.sv
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared constants for the ID-stage hazard scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;
  localparam int FP_REG_OFFSET = 32;
  localparam int LAT_ALU       = 1;
  localparam int LAT_LOAD      = 2;
  localparam int LAT_FP_ADD    = 4;
  localparam int LAT_FP_MUL    = 6;
  localparam int DEF_NUM_REGS  = 64;
  localparam int DEF_ADDR_W    = 6;
  localparam int DEF_MAX_LAT   = 8;
  localparam int DEF_LAT_W     = 4;
endpackage

`default_nettype wire

// File: rtl/sb_reg_counter.sv
// ============================================================================
// Module : sb_reg_counter
// Brief  : Per-register result countdown; a new reservation beats the decrement.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sb_reg_counter
  import hazard_pkg::*;
#(
  parameter int LAT_W = DEF_LAT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt,
  output logic             busy
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = (cnt_q != '0);

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module : hazard_scoreboard
// Brief  : ID-stage RAW/WAW/writeback-port scoreboard driving stall and bubble.
//          Optional stall/flush counters under HAZARD_SB_STATS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAX_LAT  = DEF_MAX_LAT,
  parameter int LAT_W    = DEF_LAT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic                id_flush,
  input  logic [ADDR_W-1:0]   id_rs,
  input  logic [ADDR_W-1:0]   id_rt,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic [ADDR_W-1:0]   id_dst,
  input  logic                id_dst_we,
  input  logic [LAT_W-1:0]    id_lat,
  output logic                pc_write,
  output logic                if_id_write,
  output logic                bubble,
  output logic                issue,
  output logic [NUM_REGS-1:0] busy
`ifdef HAZARD_SB_STATS_EN
  ,
  output logic [15:0]         stall_cycles,
  output logic [15:0]         flush_cycles
`endif
);

  logic [LAT_W-1:0]   cnt [NUM_REGS];
  logic [LAT_W-1:0]   le, le_m1;
  logic [MAX_LAT-1:0] occ_q, occ_d, occ_sh, slot;
  logic               raw, waw, wb_conflict, stall;

  always_comb begin
    if (id_lat == '0) begin
      le = LAT_W'(1);
    end else if (id_lat > LAT_W'(MAX_LAT)) begin
      le = LAT_W'(MAX_LAT);
    end else begin
      le = id_lat;
    end
    le_m1 = le - 1'b1;
  end

  // Bit k of occ means the writeback port is taken k cycles from now.
  assign occ_sh = occ_q >> 1;
  assign slot   = {{(MAX_LAT-1){1'b0}}, 1'b1} << le_m1;

  assign raw = (id_rs_used && (cnt[id_rs] != '0)) ||
               (id_rt_used && (cnt[id_rt] != '0));
  assign waw = id_dst_we && (id_dst != '0) && (cnt[id_dst] > le_m1);
  assign wb_conflict = id_dst_we && ((occ_sh & slot) != '0);

  assign stall       = id_valid && !id_flush && (raw || waw || wb_conflict);
  assign pc_write    = !stall;
  assign if_id_write = !stall;
  assign bubble      = stall || id_flush || !id_valid;
  assign issue       = id_valid && !id_flush && !stall;

  always_comb begin
    occ_d = occ_sh;
    if (issue && id_dst_we) begin
      occ_d = occ_sh | slot;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  // Register 0 is hardwired zero and never has a pending result.
  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    sb_reg_counter #(
      .LAT_W(LAT_W)
    ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .load    (issue && id_dst_we && (id_dst == ADDR_W'(r))),
      .load_val(le_m1),
      .cnt     (cnt[r]),
      .busy    (busy[r])
    );
  end

`ifdef HAZARD_SB_STATS_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_cycles_q, flush_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_cycles_d = flush_cycles_q;
    if (stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
    if (id_flush && (flush_cycles_q != 16'hFFFF)) begin
      flush_cycles_d = flush_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_cycles = flush_cycles_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module : tb_hazard_scoreboard
// Brief  : Self-checking bench: ready-time/writeback-slot model, directed
//          scenarios and randomized traffic. Honours HAZARD_SB_STATS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_flush, id_rs_used, id_rt_used, id_dst_we;
  logic [5:0]  id_rs, id_rt, id_dst;
  logic [3:0]  id_lat;
  logic        pc_write, if_id_write, bubble, issue;
  logic [63:0] busy;
`ifdef HAZARD_SB_STATS_EN
  logic [15:0] stall_cycles, flush_cycles;
`endif

  hazard_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_flush   (id_flush),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .id_dst     (id_dst),
    .id_dst_we  (id_dst_we),
    .id_lat     (id_lat),
    .pc_write   (pc_write),
    .if_id_write(if_id_write),
    .bubble     (bubble),
    .issue      (issue),
    .busy       (busy)
`ifdef HAZARD_SB_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_cycles(flush_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Model: absolute cycle at which each register's result becomes forwardable,
  // and the absolute cycles on which the writeback port is already claimed.
  int now = 0;
  int ready_at [64];
  int wb_slot  [16];
  int stall_m, flush_m;
  int n_checks = 0;
  int n_fail   = 0;
  int pool [8] = '{0, 1, 2, 3, 5, 33, 34, 40};

  always @(posedge clk) now <= now + 1;

  function automatic int eff_lat(input int lat);
    if (lat == 0) return 1;
    if (lat > 8) return 8;
    return lat;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, now);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 64; r++) ready_at[r] = 0;
    for (int s = 0; s < 16; s++) wb_slot[s] = -1;
    stall_m = 0;
    flush_m = 0;
  endtask

  task automatic step(input bit v, input bit f, input int rs, input bit rsu,
                      input int rt, input bit rtu, input int dst, input bit we,
                      input int lat);
    int          le;
    bit          raw, waw, strc, stl, iss;
    logic [63:0] busy_e;
    @(negedge clk);
    id_valid = v; id_flush = f;
    id_rs = 6'(rs); id_rs_used = rsu;
    id_rt = 6'(rt); id_rt_used = rtu;
    id_dst = 6'(dst); id_dst_we = we; id_lat = 4'(lat);
    #1;
    le   = eff_lat(lat);
    raw  = (rsu && ready_at[rs] > now) || (rtu && ready_at[rt] > now);
    waw  = we && dst != 0 && (ready_at[dst] - now) > (le - 1);
    strc = we && wb_slot[(now + le) % 16] == now + le;
    stl  = v && !f && (raw || waw || strc);
    iss  = v && !f && !stl;
    busy_e = '0;
    for (int r = 1; r < 64; r++) busy_e[r] = (ready_at[r] > now);
    check("pc_write",    64'(pc_write),    64'(!stl));
    check("if_id_write", 64'(if_id_write), 64'(!stl));
    check("bubble",      64'(bubble),      64'(stl || f || !v));
    check("issue",       64'(issue),       64'(iss));
    check("busy",        busy,             busy_e);
    if (iss && we) begin
      if (dst != 0) ready_at[dst] = now + le;
      wb_slot[(now + le) % 16] = now + le;
    end
    if (stl) stall_m++;
    if (f) flush_m++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    id_valid = 0; id_flush = 0; id_rs_used = 0; id_rt_used = 0; id_dst_we = 0;
    reset = 1;
    #1;
    check("reset_busy",     busy,          64'd0);
    check("reset_pc_write", 64'(pc_write), 64'd1);
    check("reset_issue",    64'(issue),    64'd0);
    check("reset_bubble",   64'(bubble),   64'd1);
    model_clear();
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  initial begin
    int n;
    reset = 1;
    id_valid = 0; id_flush = 0; id_rs = 0; id_rt = 0; id_rs_used = 0;
    id_rt_used = 0; id_dst = 0; id_dst_we = 0; id_lat = 0;
    model_clear();
    do_reset();

    // Load then dependent: exactly one bubble.
    step(1, 0, 0, 0, 0, 0, 5, 1, 2);
    check("load_issue", 64'(issue), 64'd1);
    step(1, 0, 5, 1, 0, 0, 0, 0, 1);
    check("load_dep_pc_write", 64'(pc_write), 64'd0);
    check("load_dep_bubble",   64'(bubble),   64'd1);
    step(1, 0, 5, 1, 0, 0, 0, 0, 1);
    check("load_dep_issue", 64'(issue), 64'd1);
    idle(10);

    // ALU chain through reg 3, plus reg 0 as source/destination.
    step(1, 0, 0, 1, 0, 0, 3, 1, 1);
    check("alu_issue0", 64'(issue), 64'd1);
    step(1, 0, 3, 1, 0, 1, 0, 1, 1);
    check("alu_issue1",  64'(issue),   64'd1);
    check("alu_busy3",   64'(busy[3]), 64'd0);
    check("reg0_busy0",  64'(busy[0]), 64'd0);
    idle(10);

    // FP long op then dependent on rt: five stall cycles.
    step(1, 0, 0, 0, 0, 0, 33, 1, 6);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0, 33, 1, 0, 0, 1);
      if (issue) break;
      n++;
    end
    check("fp_stall_count", 64'(n), 64'd5);
    idle(10);

    // Writeback port conflict: L=4 then independent L=3.
    step(1, 0, 0, 0, 0, 0, 34, 1, 4);
    step(1, 0, 0, 0, 0, 0, 7, 1, 3);
    check("wb_conflict_issue", 64'(issue), 64'd0);
    step(1, 0, 0, 0, 0, 0, 7, 1, 3);
    check("wb_after_issue", 64'(issue), 64'd1);
    idle(10);

    // WAW: younger L=1 write to reg 40 waits for the older L=6 write.
    step(1, 0, 0, 0, 0, 0, 40, 1, 6);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0, 0, 0, 40, 1, 1);
      if (issue) break;
      n++;
    end
    check("waw_stall_count", 64'(n), 64'd5);
    idle(10);

    // Flush with a RAW pending: squashed, no stall.
    step(1, 0, 0, 0, 0, 0, 5, 1, 2);
    step(1, 1, 5, 1, 0, 0, 0, 0, 1);
    check("flush_issue",    64'(issue),    64'd0);
    check("flush_pc_write", 64'(pc_write), 64'd1);
    check("flush_bubble",   64'(bubble),   64'd1);
    idle(10);

    // Reset while reg 33 is still pending.
    step(1, 0, 0, 0, 0, 0, 33, 1, 6);
    idle(1);
    check("pre_reset_busy33", 64'(busy[33]), 64'd1);
    do_reset();
    step(1, 0, 0, 0, 33, 1, 0, 0, 1);
    check("post_reset_issue", 64'(issue), 64'd1);

    // Randomized traffic over a small register pool to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step($urandom % 10 != 0, $urandom % 10 == 0,
           pool[$urandom % 8], $urandom % 2 == 0,
           pool[$urandom % 8], $urandom % 2 == 0,
           pool[$urandom % 8], $urandom % 4 != 0,
           int'($urandom_range(0, 10)));
    end

`ifdef HAZARD_SB_STATS_EN
    @(posedge clk);
    #1;
    check("stall_cycles", 64'(stall_cycles), 64'(stall_m));
    check("flush_cycles", 64'(flush_cycles), 64'(flush_m));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
